ntm_design: RTL and testbench

NTM_DESIGN -- requirements
Module: ntm_design

---
 rtl/ntm_design.sv | 37 +++
 tb/tb_ntm_design.sv | 109 ++++++++++
 2 files changed

// File: rtl/ntm_design.sv
// rtl/ntm_design.sv - two-stage pipelined unsigned adder, carry kept in the result MSB
module ntm_design #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in1,
  input  logic [DATA_WIDTH-1:0] in2,
  output logic [DATA_WIDTH:0]   out
);

  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [DATA_WIDTH:0]   sum_q, sum_d;

  // Operands are widened before the add so the carry lands in the MSB instead of wrapping.
  always_comb begin
    a_d   = in1;
    b_d   = in2;
    sum_d = {1'b0, a_q} + {1'b0, b_q};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      sum_q <= sum_d;
    end
  end

  assign out = sum_q;

endmodule

// File: tb/tb_ntm_design.sv
// tb/tb_ntm_design.sv - randomized and directed checks of ntm_design against a delayed-sum model
module tb_ntm_design;

  logic       clk;
  logic       rst;
  logic [7:0] in1;
  logic [7:0] in2;
  logic [8:0] out;

  int errors = 0;
  int checks = 0;

  // Expected out values for the upcoming falling edges, oldest first.
  int exp_q[$];

  ntm_design #(.DATA_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .in1 (in1),
    .in2 (in2),
    .out (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    if (obs != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic apply(input int a, input int b);
    in1 = a[7:0];
    in2 = b[7:0];
    exp_q.push_back(a + b);
  endtask

  task automatic step(input string tag, input int a, input int b);
    int e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check({tag, "_model_empty"}, exp_q.size(), 1);
    end else begin
      e = exp_q.pop_front();
      check(tag, int'(out), e);
    end
    apply(a, b);
  endtask

  // Drops reset between edges, checks the clear is immediate, then releases on a falling edge.
  task automatic async_reset(input int a, input int b);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check("async_rst_clear", int'(out), 0);
    @(posedge clk);
    #2 check("async_rst_hold", int'(out), 0);
    @(negedge clk);
    check("async_rst_release", int'(out), 0);
    rst = 1'b1;
    exp_q.delete();
    exp_q.push_back(0);
    apply(a, b);
  endtask

  initial begin
    rst = 1'b0;
    in1 = 8'd5;
    in2 = 8'd2;
    #1 check("reset_initial", int'(out), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #2 check("reset_hold_edge", int'(out), 0);
      @(negedge clk);
      check("reset_hold_mid", int'(out), 0);
    end

    rst = 1'b1;
    exp_q.push_back(0);
    apply(5, 2);
    step("first_before", 0, 0);
    step("first_sum", 255, 255);
    step("zero", 255, 1);
    step("max_510", 0, 0);
    step("carry_256", 1, 1);
    step("zero_zero", 2, 3);
    step("b2b_2", 100, 200);
    step("b2b_5", 7, 9);
    step("b2b_300", 10, 20);

    async_reset(40, 50);
    step("post_rst_zero", 60, 70);
    step("post_rst_first", 0, 0);
    step("post_rst_second", 0, 0);

    for (int i = 0; i < 1000; i++) begin
      if (i == 500) async_reset($urandom_range(0, 255), $urandom_range(0, 255));
      else step("random", $urandom_range(0, 255), $urandom_range(0, 255));
    end
    step("flush", 0, 0);
    step("flush", 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
